// File: rtl/load_align_unit.sv
// load_align_unit
// Memory-stage load sequencer. It accepts one load at a time from the pipeline
// and issues word-aligned reads over a valid/ready memory port. A load that
// crosses a word boundary is serviced with two reads whose data are merged.
// The unit returns a low-justified 32-bit word: the addressed byte lands in
// BaseResult[7:0], and the next stage narrows and extends it.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   - a load that would cross a word boundary makes no memory
//               access. It completes at once with BaseResult = 0 and a
//               MisalignErr pulse.
//   undefined - a boundary-crossing load is serviced with two reads, and
//               MisalignErr is tied low.
//
// The reset port is named 'reset'. It is asynchronous and active-low.

module load_align_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  LoadReq,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [2:0]            WidthSrc,
  output logic                  Stall,
  output logic [31:0]           BaseResult,
  output logic                  ResultValid,
  output logic                  MisalignErr,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemReady,
  input  logic [31:0]           MemRdata,
  input  logic                  MemRvalid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state;
  state_t nextState;

  // Values captured when the load is accepted.
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [1:0]            offReg;
  logic                  splitReg;
  logic [31:0]           loReg;

`ifdef MISALIGN_TRAP_EN
  logic                  trapReg;
`endif

  // Decode of the incoming request.
  logic [2:0]            reqSize;
  logic                  reqSplit;
  logic [ADDR_WIDTH-1:0] secondAddr;
  logic [4:0]            loShift;
  logic [4:0]            hiShift;

  // The signed/unsigned bit is used only by the downstream extension stage.
  logic                  unusedSignBit;
  assign unusedSignBit = WidthSrc[2];

  assign secondAddr = wordAddr + ADDR_WIDTH'(4);
  assign loShift    = {offReg, 3'b000};
  // For a split load the offset is nonzero. 0 - loShift (mod 32) then equals
  // 32 - 8*off, which is where the second word's bytes start.
  assign hiShift    = 5'd0 - loShift;

  // Decode the access size. Unlisted codes fall back to a full word.
  always_comb begin
    reqSize = 3'd4;
    case (WidthSrc[1:0])
      2'b10:   reqSize = 3'd2;
      2'b01:   reqSize = 3'd1;
      default: reqSize = 3'd4;
    endcase
    reqSplit = (({1'b0, Addr[1:0]} + reqSize) > 3'd4);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state sequencing through the one or two memory reads.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (LoadReq) begin
`ifdef MISALIGN_TRAP_EN
          nextState = reqSplit ? DONE : REQ0;
`else
          nextState = REQ0;
`endif
        end
      end
      REQ0:    if (MemReady)  nextState = WAIT0;
      WAIT0:   if (MemRvalid) nextState = splitReg ? REQ1 : DONE;
      REQ1:    if (MemReady)  nextState = WAIT1;
      WAIT1:   if (MemRvalid) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Pipeline and memory-port outputs, decoded from the current state.
  always_comb begin
    Stall       = 1'b0;
    MemReq      = 1'b0;
    MemAddr     = '0;
    ResultValid = 1'b0;
    MisalignErr = 1'b0;
    case (state)
      // Gate with reset so that Stall stays low while reset is asserted.
      IDLE:  Stall = LoadReq & reset;
      REQ0: begin
        Stall   = 1'b1;
        MemReq  = 1'b1;
        MemAddr = wordAddr;
      end
      WAIT0: Stall = 1'b1;
      REQ1: begin
        Stall   = 1'b1;
        MemReq  = 1'b1;
        MemAddr = secondAddr;
      end
      WAIT1: Stall = 1'b1;
      DONE: begin
        ResultValid = 1'b1;
`ifdef MISALIGN_TRAP_EN
        MisalignErr = trapReg;
`endif
      end
      default: ;
    endcase
  end

  // Capture the request, collect the read data and build the aligned result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wordAddr   <= '0;
      offReg     <= 2'b00;
      splitReg   <= 1'b0;
      loReg      <= 32'h0;
      BaseResult <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      trapReg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (LoadReq) begin
            wordAddr <= {Addr[ADDR_WIDTH-1:2], 2'b00};
            offReg   <= Addr[1:0];
            splitReg <= reqSplit;
`ifdef MISALIGN_TRAP_EN
            trapReg  <= reqSplit;
            if (reqSplit) begin
              BaseResult <= 32'h0;
            end
`endif
          end
        end
        WAIT0: begin
          if (MemRvalid) begin
            loReg <= MemRdata;
            if (!splitReg) begin
              BaseResult <= MemRdata >> loShift;
            end
          end
        end
        WAIT1: begin
          if (MemRvalid) begin
            BaseResult <= (loReg >> loShift) | (MemRdata << hiShift);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
// Self-checking bench for load_align_unit. A behavioural memory responder
// serves word 0x100 = 0x44332211 and word 0x104 = 0x88776655. Each test task
// queues the expected result and the expected read addresses, runs the load,
// and compares what the DUT returns. Splits are checked against the trap
// behaviour when MISALIGN_TRAP_EN is defined.

module tb_load_align_unit;

  logic        clk;
  logic        reset;
  logic        LoadReq;
  logic [31:0] Addr;
  logic [2:0]  WidthSrc;
  logic        Stall;
  logic [31:0] BaseResult;
  logic        ResultValid;
  logic        MisalignErr;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemReady  = 1'b1;
  logic [31:0] MemRdata  = 32'h0;
  logic        MemRvalid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Memory responder controls
  int          rvalidDelay  = 1;
  int          readyLowLeft = 0;
  bit          injectRvalid = 0;
  bit          pending      = 0;
  bit          willAccept   = 0;
  int          delayCnt     = 0;
  logic [31:0] pendAddr     = 32'h0;
  logic [31:0] reqLog[$];

  // Scoreboard
  logic [31:0] expQ[$];
  logic [31:0] expAddrQ[$];

  // Observations gathered while a load runs
  int          startCycle;
  logic [31:0] obsRes;
  int          obsLat;
  logic        obsErr;
  bit          obsTimeout, obsStallBad, obsAddrBad, obsPulseBad;
  logic        obsStallIssue;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  w;
    logic [31:0] res;
    int          lat;
    int          nReq;
    logic        err;
  } loadVec_t;

  load_align_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .LoadReq(LoadReq), .Addr(Addr), .WidthSrc(WidthSrc),
    .Stall(Stall), .BaseResult(BaseResult), .ResultValid(ResultValid),
    .MisalignErr(MisalignErr), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemReady(MemReady), .MemRdata(MemRdata), .MemRvalid(MemRvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h100) return 32'h44332211;
    if (a == 32'h104) return 32'h88776655;
    return {a[15:0], 16'hA5A5};
  endfunction

  // Responder: decide the ready/response signals on the falling edge.
  always @(negedge clk) begin
    MemRvalid = 1'b0;
    willAccept = 0;
    if (!reset) begin
      pending  = 0;
      MemReady = 1'b1;
    end else begin
      if (injectRvalid) begin
        MemRvalid    = 1'b1;
        MemRdata     = 32'hBAD0BAD0;
        injectRvalid = 0;
      end
      if (pending) begin
        if (delayCnt <= 1) begin
          MemRvalid = 1'b1;
          MemRdata  = memWord(pendAddr);
          pending   = 0;
        end else begin
          delayCnt--;
        end
      end
      if (MemReq === 1'b1 && !pending) begin
        if (readyLowLeft > 0) begin
          MemReady = 1'b0;
          readyLowLeft--;
        end else begin
          MemReady   = 1'b1;
          willAccept = 1;
          pendAddr   = MemAddr;
        end
      end else begin
        MemReady = 1'b1;
      end
    end
  end

  // Responder: count cycles and log each request accepted on this edge.
  always @(posedge clk) begin
    cycle++;
    if (willAccept && reset) begin
      reqLog.push_back(pendAddr);
      pending  = 1;
      delayCnt = rvalidDelay;
    end
    willAccept = 0;
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [2:0] w,
                               input logic [31:0] res, input int nReq);
    LoadReq    = 1'b1;
    Addr       = a;
    WidthSrc   = w;
    startCycle = cycle;
    expQ.push_back(res);
    if (nReq >= 1) expAddrQ.push_back({a[31:2], 2'b00});
    if (nReq >= 2) expAddrQ.push_back({a[31:2], 2'b00} + 32'd4);
    #1;
    obsStallIssue = Stall;
  endtask

  task automatic waitResult();
    bit seen = 0;
    obsTimeout = 1; obsStallBad = 0; obsAddrBad = 0; obsPulseBad = 0;
    obsRes = 32'hx; obsErr = 1'bx; obsLat = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) LoadReq = 1'b0;
      #1;
      if (MemReq === 1'b1) begin
        if (reqLog.size() >= expAddrQ.size()) obsAddrBad = 1;
        else if (MemAddr !== expAddrQ[reqLog.size()]) obsAddrBad = 1;
      end
      if (ResultValid === 1'b1) begin
        seen = 1; obsTimeout = 0;
        obsRes = BaseResult; obsErr = MisalignErr; obsLat = cycle - startCycle;
        if (Stall !== 1'b0) obsStallBad = 1;
      end else if (Stall !== 1'b1) begin
        obsStallBad = 1;
      end
    end
    @(negedge clk);
    #1;
    if (ResultValid !== 1'b0) obsPulseBad = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; LoadReq = 1'b1; Addr = 32'h100; WidthSrc = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("[TB] FAIL reset Stall: got %b expected 0", Stall); end
    checks++; if (MemReq !== 1'b0 || MemAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset MemReq/MemAddr: got %b/%h expected 0/0", MemReq, MemAddr); end
    checks++; if (ResultValid !== 1'b0 || MisalignErr !== 1'b0) begin errors++; $display("[TB] FAIL reset pulses: got %b/%b expected 0/0", ResultValid, MisalignErr); end
    checks++; if (BaseResult !== 32'h0) begin errors++; $display("[TB] FAIL reset BaseResult: got %h expected 0", BaseResult); end
    LoadReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Shared by every load-table test: compare one completed load to the scoreboard.
  task automatic checkOutput(input string name, input loadVec_t v);
    logic [31:0] expRes;
    expRes = expQ.pop_front();
    checks++; if (obsTimeout) begin errors++; $display("[TB] FAIL %s timeout: got no ResultValid expected one", name); end
    checks++; if (obsRes !== expRes) begin errors++; $display("[TB] FAIL %s BaseResult: got %h expected %h", name, obsRes, expRes); end
    checks++; if (obsLat != v.lat) begin errors++; $display("[TB] FAIL %s latency: got %0d expected %0d", name, obsLat, v.lat); end
    checks++; if (obsErr !== v.err) begin errors++; $display("[TB] FAIL %s MisalignErr: got %b expected %b", name, obsErr, v.err); end
    checks++; if (obsStallIssue !== 1'b1 || obsStallBad) begin errors++; $display("[TB] FAIL %s Stall: got issue=%b bad=%0d expected 1/0", name, obsStallIssue, obsStallBad); end
    checks++; if (obsAddrBad || obsPulseBad) begin errors++; $display("[TB] FAIL %s MemAddr/pulse: got addrBad=%0d pulseBad=%0d expected 0/0", name, obsAddrBad, obsPulseBad); end
    checks++; if (reqLog.size() != expAddrQ.size()) begin errors++; $display("[TB] FAIL %s read count: got %0d expected %0d", name, reqLog.size(), expAddrQ.size()); end
    while (reqLog.size() > 0 && expAddrQ.size() > 0) begin
      logic [31:0] gotA, expA;
      gotA = reqLog.pop_front();
      expA = expAddrQ.pop_front();
      checks++; if (gotA !== expA) begin errors++; $display("[TB] FAIL %s read address: got %h expected %h", name, gotA, expA); end
    end
    reqLog.delete();
    expAddrQ.delete();
  endtask

  task automatic runTable(input string name, input loadVec_t tbl[$]);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].addr, tbl[i].w, tbl[i].res, tbl[i].nReq);
      waitResult();
      checkOutput($sformatf("%s[%0d]", name, i), tbl[i]);
    end
  endtask

  task automatic test_aligned();
    loadVec_t tbl[$];
    tbl.push_back('{32'h100, 3'b000, 32'h44332211, 3, 1, 1'b0});
    runTable("aligned", tbl);
  endtask

  task automatic test_narrow();
    loadVec_t tbl[$];
    tbl.push_back('{32'h102, 3'b010, 32'h00004433, 3, 1, 1'b0});
    tbl.push_back('{32'h101, 3'b001, 32'h00443322, 3, 1, 1'b0});
    tbl.push_back('{32'h103, 3'b001, 32'h00000044, 3, 1, 1'b0});
    tbl.push_back('{32'h102, 3'b110, 32'h00004433, 3, 1, 1'b0});
    runTable("narrow", tbl);
  endtask

  task automatic test_split();
    loadVec_t tbl[$];
`ifdef MISALIGN_TRAP_EN
    tbl.push_back('{32'h102, 3'b000, 32'h0, 1, 0, 1'b1});
    tbl.push_back('{32'h103, 3'b110, 32'h0, 1, 0, 1'b1});
    tbl.push_back('{32'h102, 3'b011, 32'h0, 1, 0, 1'b1});
`else
    tbl.push_back('{32'h103, 3'b000, 32'h77665544, 5, 2, 1'b0});
    tbl.push_back('{32'h103, 3'b110, 32'h77665544, 5, 2, 1'b0});
    tbl.push_back('{32'h102, 3'b011, 32'h66554433, 5, 2, 1'b0});
`endif
    runTable("split", tbl);
  endtask

  task automatic test_backpressure();
    loadVec_t tbl[$];
    readyLowLeft = 3;
    rvalidDelay  = 2;
    tbl.push_back('{32'h100, 3'b000, 32'h44332211, 7, 1, 1'b0});
    runTable("backpressure", tbl);
    rvalidDelay = 1;
  endtask

  task automatic test_back_to_back();
    loadVec_t tbl[$];
    tbl.push_back('{32'h106, 3'b001, 32'h00008877, 3, 1, 1'b0});
    tbl.push_back('{32'h104, 3'b010, 32'h88776655, 3, 1, 1'b0});
    tbl.push_back('{32'h100, 3'b100, 32'h44332211, 3, 1, 1'b0});
    runTable("backtoback", tbl);
  endtask

  task automatic test_reset_midop();
    loadVec_t tbl[$];
    logic [31:0] dropped;
    int needReqs;
    bit reached = 0;
    bit strayBad = 0;
    rvalidDelay = 3;
`ifdef MISALIGN_TRAP_EN
    needReqs = 1;
    applyStimulus(32'h100, 3'b000, 32'h44332211, 1);
`else
    needReqs = 2;
    applyStimulus(32'h103, 3'b000, 32'h77665544, 2);
`endif
    for (int i = 0; i < 40 && !reached; i++) begin
      @(negedge clk);
      if (i == 0) LoadReq = 1'b0;
      #1;
      if (reqLog.size() >= needReqs) reached = 1;
    end
    checks++; if (!reached) begin errors++; $display("[TB] FAIL midop reach wait: got %0d reads expected %0d", reqLog.size(), needReqs); end
    reset = 1'b0;
    LoadReq = 1'b1;
    #1;
    checks++; if (Stall !== 1'b0 || MemReq !== 1'b0 || MemAddr !== 32'h0) begin errors++; $display("[TB] FAIL midop reset outputs: got Stall=%b MemReq=%b MemAddr=%h expected 0", Stall, MemReq, MemAddr); end
    checks++; if (BaseResult !== 32'h0 || ResultValid !== 1'b0 || MisalignErr !== 1'b0) begin errors++; $display("[TB] FAIL midop reset result: got %h/%b/%b expected 0/0/0", BaseResult, ResultValid, MisalignErr); end
    repeat (2) @(negedge clk);
    LoadReq = 1'b0;
    dropped = expQ.pop_front();
    reqLog.delete();
    expAddrQ.delete();
    rvalidDelay = 1;
    #2;
    reset = 1'b1;
    injectRvalid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (ResultValid !== 1'b0 || Stall !== 1'b0 || MemReq !== 1'b0 || BaseResult !== 32'h0) strayBad = 1;
    end
    checks++; if (strayBad) begin errors++; $display("[TB] FAIL midop stray response: got activity (last %h) expected idle", dropped); end
    tbl.push_back('{32'h104, 3'b000, 32'h88776655, 3, 1, 1'b0});
    runTable("afterreset", tbl);
  endtask

  initial begin
    LoadReq = 1'b0; Addr = 32'h0; WidthSrc = 3'b000;
    $display("[TB] starting load_align_unit bench");
    test_reset();
    test_aligned();
    test_narrow();
    test_split();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Memory-stage load sequencer that sits directly upstream of the load-width reduction stage. It accepts a load from the pipeline and issues word-aligned reads over a valid/ready memory port. Loads that cross a word boundary are split into two reads and merged. It returns a low-justified 32-bit word (BaseResult) for the downstream stage to narrow and extend, and stalls the pipeline while the load is outstanding.

Parameters:
ADDR_WIDTH, 32, width of Addr and MemAddr

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
LoadReq  input  1  load instruction present in Mem stage
Addr  input  ADDR_WIDTH  byte address of load
WidthSrc  input  3  width code: 000 word, x10 half, x01 byte (bit2 = unsigned, ignored here)
Stall  output  1  freeze pipeline while load outstanding
BaseResult  output  32  merged data, addressed byte placed at bits [7:0]
ResultValid  output  1  one-cycle pulse; BaseResult valid
MisalignErr  output  1  one-cycle pulse (only with MISALIGN_TRAP_EN, else tied 0)
MemReq  output  1  read request valid
MemAddr  output  ADDR_WIDTH  word-aligned read address, bits [1:0] = 00
MemReady  input  1  memory accepts request this cycle
MemRdata  input  32  read data
MemRvalid  input  1  read data valid; at most one response per accepted request, at least 1 cycle after acceptance

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-low. While reset is low: state IDLE, and all outputs are 0, including BaseResult, MemAddr, Stall, ResultValid and MisalignErr.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE:
  - Stall = LoadReq, combinational.
  - When LoadReq is sampled high: capture Addr, off = Addr[1:0], and size (word 4, half 2, byte 1).
  - Unlisted WidthSrc codes (x11, 100) are treated as word.
  - split = (off + size > 4). Next state REQ0.
- REQ0:
  - MemReq = 1, MemAddr = {Addr[ADDR_WIDTH-1:2], 2'b00}.
  - MemReq and MemAddr are held stable until MemReady is high. On MemReady, go to WAIT0.
- WAIT0: on MemRvalid, register lo = MemRdata. Next state is REQ1 if split, else DONE.
- REQ1: same as REQ0, with MemAddr = captured word address + 4 (wraps modulo 2^ADDR_WIDTH). On MemReady, go to WAIT1.
- WAIT1: on MemRvalid, register hi = MemRdata, then go to DONE.
- DONE:
  - ResultValid = 1 and Stall = 0 for exactly one cycle, then IDLE.
  - LoadReq is ignored in DONE; the pipeline advances on this edge.
- BaseResult (registered, held until next DONE):
  - non-split: lo >> (8*off)
  - split: (lo >> (8*off)) | (hi << (8*(4-off)))
  - upper bits beyond size are don't-care for downstream; they are produced as above.
- Stall = 1 in REQ0, WAIT0, REQ1 and WAIT1.
- Aligned-load latency with MemReady high and MemRvalid one cycle after acceptance: LoadReq cycle N -> ResultValid cycle N+3. Split load: N+5.
- MemRvalid in IDLE, REQ* or DONE is ignored. MemRvalid is ignored in WAIT0/WAIT1 until it is high.
- Reset mid-operation returns to IDLE immediately. A response arriving after reset is ignored.
- Only one load is ever outstanding.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: when split would be 1, no memory access is made. Next state is DONE with BaseResult = 0, ResultValid = 1 and MisalignErr = 1 for that cycle. Latency is N+1.
- Undefined: split loads are serviced with two reads as above, and MisalignErr is constant 0.

Test Plan:
Memory contents for all scenarios: word 0x100 = 0x44332211, word 0x104 = 0x88776655. Unless stated, MemReady = 1 and MemRvalid arrives one cycle after acceptance.
- Word load at Addr 0x100: one MemReq, MemAddr 0x100, ResultValid at N+3, BaseResult 0x44332211, Stall high for cycles N..N+2.
- Half load at Addr 0x102: one MemReq to 0x100, BaseResult 0x00004433. Byte load at Addr 0x101: BaseResult 0x00443322.
- Word load at Addr 0x103: two reads, 0x100 then 0x104, ResultValid at N+5, BaseResult 0x77665544. Half load at Addr 0x103: same two reads, BaseResult[15:0] = 0x5544.
- Aligned word load with MemReady low for 3 cycles and MemRvalid 2 cycles after acceptance: MemReq and MemAddr stable while waiting, Stall held, BaseResult 0x44332211, exactly one ResultValid pulse.
- reset driven low in WAIT1, then a stray MemRvalid after reset release: all outputs 0, state IDLE, no ResultValid. A following load at 0x104 returns 0x88776655.
- With MISALIGN_TRAP_EN, word load at 0x102: no MemReq, MisalignErr and ResultValid pulse at N+1, BaseResult 0.
